// File: rtl/note_decoder.sv
// note_decoder: measures the half-period of a square-wave tone line and
// identifies which of eight scale notes (C4..C5) is playing.
//
// Ports:
//   clk         in   system clock (50 MHz)
//   rst_n       in   synchronous active-low reset
//   tone_in     in   square-wave tone line, asynchronous to clk
//   note_valid  out  high while a note is locked
//   note_onehot out  one-hot locked note, bit0=C4 .. bit7=C5, zero when unlocked
//   note_code   out  binary index of locked note, zero when unlocked
//   silent      out  no tone_in edge for TIMEOUT cycles, and after reset
module note_decoder #(
    parameter int TOL        = 1000,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 131071,
    // Nominal half-periods in clk cycles, NOM[0]=C4 .. NOM[7]=C5
    parameter logic [7:0][16:0] NOM = {
        17'd47778, 17'd50619, 17'd56818, 17'd63776,
        17'd71586, 17'd75843, 17'd85131, 17'd95556
    }
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    output logic       note_valid,
    output logic [7:0] note_onehot,
    output logic [2:0] note_code,
    output logic       silent
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [16:0] TMO   = 17'(TIMEOUT);
    localparam logic [16:0] TOL_W = 17'(TOL);
    localparam logic [3:0]  LC    = 4'(LOCK_COUNT);

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [16:0] cnt_q, cnt_d;
    logic [3:0]  mcnt_q, mcnt_d;
    logic [2:0]  cand_q, cand_d;
    logic        pend_q, pend_d;
    logic        valid_q, valid_d;
    logic [7:0]  onehot_q, onehot_d;
    logic [2:0]  code_q, code_d;
    logic        silent_q, silent_d;

    logic        edge_w;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [16:0] diff;
    logic [3:0]  mcnt_nx;
    logic [2:0]  cand_nx;

    assign edge_w = s2_q ^ s3_q;

    // cnt_q holds the just-finished half-period on an edge cycle
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        diff    = '0;
        for (int i = 0; i < 8; i++) begin
            if (cnt_q >= NOM[i]) diff = cnt_q - NOM[i];
            else                 diff = NOM[i] - cnt_q;
            if (diff <= TOL_W) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        s1_d     = tone_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        mcnt_d   = mcnt_q;
        cand_d   = cand_q;
        pend_d   = pend_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        code_d   = code_q;
        silent_d = silent_q;
        mcnt_nx  = mcnt_q;
        cand_nx  = cand_q;

        if (edge_w)          cnt_d = 17'd1;
        else if (cnt_q == TMO) cnt_d = cnt_q;
        else                 cnt_d = cnt_q + 17'd1;

        unique case (state_q)
            IDLE: begin
                // pend_q carries an edge that collided with the timeout
                if (edge_w || pend_q) begin
                    state_d  = ACQUIRE;
                    silent_d = 1'b0;
                    pend_d   = 1'b0;
                end
            end
            ACQUIRE, LOCKED: begin
                if (cnt_q == TMO) begin
                    state_d  = IDLE;
                    silent_d = 1'b1;
                    valid_d  = 1'b0;
                    onehot_d = 8'd0;
                    code_d   = 3'd0;
                    mcnt_d   = 4'd0;
                    pend_d   = edge_w;
                end else if (edge_w) begin
                    if (state_q == LOCKED) begin
                        if (!(hit && hit_idx == cand_q)) begin
                            state_d  = ACQUIRE;
                            valid_d  = 1'b0;
                            onehot_d = 8'd0;
                            code_d   = 3'd0;
                            if (hit) begin
                                cand_d = hit_idx;
                                mcnt_d = 4'd1;
                            end else begin
                                mcnt_d = 4'd0;
                            end
                        end
                    end else begin
                        if (hit && hit_idx == cand_q && mcnt_q != 4'd0) begin
                            mcnt_nx = mcnt_q + 4'd1;
                        end else if (hit) begin
                            cand_nx = hit_idx;
                            mcnt_nx = 4'd1;
                        end else begin
                            mcnt_nx = 4'd0;
                        end
                        mcnt_d = mcnt_nx;
                        cand_d = cand_nx;
                        if (mcnt_nx >= LC) begin
                            state_d  = LOCKED;
                            valid_d  = 1'b1;
                            onehot_d = 8'b1 << cand_nx;
                            code_d   = cand_nx;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            mcnt_q   <= '0;
            cand_q   <= '0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
            code_q   <= '0;
            silent_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
            cand_q   <= cand_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            code_q   <= code_d;
            silent_q <= silent_d;
        end
    end

    assign note_valid  = valid_q;
    assign note_onehot = onehot_q;
    assign note_code   = code_q;
    assign silent      = silent_q;

endmodule

// File: tb/tb_note_decoder.sv
// tb_note_decoder: note_decoder against a behavioural note-lock model,
// directed scenarios plus randomized tone segments.
module tb_note_decoder;

    localparam int TOL     = 10;
    localparam int LOCK    = 4;
    localparam int TIMEOUT = 1311;
    localparam int NOMS[8] = '{956, 851, 758, 716, 638, 568, 506, 478};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tone_in;
    logic       note_valid;
    logic [7:0] note_onehot;
    logic [2:0] note_code;
    logic       silent;

    int errors = 0;
    int checks = 0;
    int nprint = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    note_decoder #(
        .TOL(TOL),
        .LOCK_COUNT(LOCK),
        .TIMEOUT(TIMEOUT),
        .NOM({17'd478, 17'd506, 17'd568, 17'd638,
              17'd716, 17'd758, 17'd851, 17'd956})
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tone_in(tone_in),
        .note_valid(note_valid),
        .note_onehot(note_onehot),
        .note_code(note_code),
        .silent(silent)
    );

    typedef struct {
        int since;
        bit silent;
        int locked;
        int cand;
        int streak;
        bit pend;
        bit h_a;
        bit h_b;
        bit h_c;
    } mdl_t;

    mdl_t m;

    function automatic int classify(int meas);
        int d;
        for (int i = 0; i < 8; i++) begin
            d = (meas > NOMS[i]) ? meas - NOMS[i] : NOMS[i] - meas;
            if (d <= TOL) return i;
        end
        return -1;
    endfunction

    // One clock of the model; h_a/h_b/h_c are the last three tone samples
    function automatic mdl_t step(mdl_t s, logic tin, logic rn);
        mdl_t r;
        bit ev;
        int n;
        r = s;
        if (!rn) begin
            r.h_a = 0; r.h_b = 0; r.h_c = 0;
            r.since = 0; r.silent = 1; r.locked = -1;
            r.cand = 0; r.streak = 0; r.pend = 0;
            return r;
        end
        ev = (s.h_b != s.h_c);
        r.h_c = s.h_b;
        r.h_b = s.h_a;
        r.h_a = tin;
        r.since = ev ? 1 : (s.since < TIMEOUT ? s.since + 1 : TIMEOUT);
        if (s.silent) begin
            if (ev || s.pend) begin
                r.silent = 0;
                r.pend = 0;
            end
        end else if (s.since == TIMEOUT) begin
            r.silent = 1;
            r.locked = -1;
            r.streak = 0;
            r.pend = ev;
        end else if (ev) begin
            n = classify(s.since);
            if (s.locked >= 0) begin
                if (n != s.locked) begin
                    r.locked = -1;
                    if (n >= 0) begin
                        r.cand = n;
                        r.streak = 1;
                    end else begin
                        r.streak = 0;
                    end
                end
            end else begin
                if (n >= 0 && n == s.cand && s.streak > 0) begin
                    r.streak = s.streak + 1;
                end else if (n >= 0) begin
                    r.cand = n;
                    r.streak = 1;
                end else begin
                    r.streak = 0;
                end
                if (r.streak >= LOCK) r.locked = r.cand;
            end
        end
        return r;
    endfunction

    function automatic logic [12:0] expv(mdl_t s);
        logic [7:0] oh;
        logic [2:0] cd;
        oh = (s.locked >= 0) ? (8'b1 << s.locked) : 8'd0;
        cd = (s.locked >= 0) ? 3'(s.locked) : 3'd0;
        return {s.locked >= 0, oh, cd, s.silent};
    endfunction

    always @(posedge clk) m <= step(m, tone_in, rst_n);

    always @(negedge clk) begin
        logic [12:0] e;
        if (chk_en) begin
            e = expv(m);
            checks++;
            if ({note_valid, note_onehot, note_code, silent} !== e) begin
                errors++;
                if (nprint < 10) begin
                    nprint++;
                    $display("FAIL cycle_cmp t=%0t got v=%b oh=%b code=%0d sil=%b required v=%b oh=%b code=%0d sil=%b",
                             $time, note_valid, note_onehot, note_code, silent,
                             e[12], e[11:4], e[3:1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic half(input int h);
        @(negedge clk);
        tone_in = ~tone_in;
        repeat (h - 1) @(negedge clk);
    endtask

    task automatic wave(input int h, input int n);
        repeat (n) half(h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tone_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sel, note, dh, n;
        tone_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_silent", silent, 1);
        chk("rst_valid", note_valid, 0);
        chk("rst_onehot", note_onehot, 0);
        chk("rst_code", note_code, 0);

        wave(956, 4);
        chk("c4_prelock", note_valid, 0);
        chk("c4_silent", silent, 0);
        half(956);
        chk("c4_valid", note_valid, 1);
        chk("c4_onehot", note_onehot, 1);
        chk("c4_code", note_code, 0);
        wave(956, 2);
        chk("c4_hold", note_valid, 1);

        do_reset();
        wave(577, 5);
        chk("a4_in_tol_valid", note_valid, 1);
        chk("a4_in_tol_code", note_code, 5);
        chk("a4_in_tol_onehot", note_onehot, 32);

        do_reset();
        wave(580, 7);
        chk("a4_out_tol_valid", note_valid, 0);
        chk("a4_out_tol_silent", silent, 0);

        do_reset();
        wave(638, 5);
        chk("g4_code", note_code, 4);
        half(478);
        chk("g4_last_edge", note_valid, 1);
        half(478);
        chk("g4_to_c5_clear", note_valid, 0);
        wave(478, 2);
        chk("c5_prelock", note_valid, 0);
        half(478);
        chk("c5_valid", note_valid, 1);
        chk("c5_code", note_code, 7);
        chk("c5_onehot", note_onehot, 128);

        do_reset();
        wave(758, 5);
        chk("e4_code", note_code, 2);
        repeat (TIMEOUT - 5 - 757) @(negedge clk);
        chk("e4_pre_timeout_silent", silent, 0);
        chk("e4_pre_timeout_valid", note_valid, 1);
        repeat (10) @(negedge clk);
        chk("e4_timeout_silent", silent, 1);
        chk("e4_timeout_valid", note_valid, 0);
        chk("e4_timeout_code", note_code, 0);
        wave(758, 4);
        chk("e4_relock_pre", note_valid, 0);
        chk("e4_relock_silent", silent, 0);
        half(758);
        chk("e4_relock_valid", note_valid, 1);
        chk("e4_relock_code", note_code, 2);

        do_reset();
        wave(716, 5);
        chk("f4_code", note_code, 3);
        half(300);
        chk("f4_pre_glitch", note_valid, 1);
        half(40);
        chk("f4_glitch_unlock", note_valid, 0);
        half(376);
        half(716);
        wave(716, 3);
        chk("f4_relock_pre", note_valid, 0);
        half(716);
        chk("f4_relock_valid", note_valid, 1);
        chk("f4_relock_code", note_code, 3);

        do_reset();
        wave(851, 5);
        chk("d4_code", note_code, 1);
        do_reset();
        chk("d4_rst_valid", note_valid, 0);
        chk("d4_rst_silent", silent, 1);
        chk("d4_rst_onehot", note_onehot, 0);
        chk("d4_rst_code", note_code, 0);
        wave(851, 4);
        chk("d4_relock_pre", note_valid, 0);
        half(851);
        chk("d4_relock_valid", note_valid, 1);
        chk("d4_relock_code", note_code, 1);

        for (int seg = 0; seg < 12; seg++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                half(int'($urandom_range(20, 400)));
            end else if (sel == 1) begin
                do_reset();
            end else if (sel == 2) begin
                half(TIMEOUT - 2 + int'($urandom_range(0, 4)));
            end else begin
                note = int'($urandom_range(0, 7));
                dh = int'($urandom_range(0, 28)) - 14;
                n = int'($urandom_range(1, 5));
                wave(NOMS[note] + dh, n);
            end
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
